// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type
// and the access-legality check used at request acceptance.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Misaligned halfword/word or a funct3 that has no RV32 meaning.
    // Store 011 (RV64 SD) has no word-sized meaning here, so it is rejected too.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
        logic illegal;
        logic misal;
        if (we)
            illegal = f3[2] || (f3[1:0] == 2'b11);
        else
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misal = ((f3[1:0] == 2'b01) && a[0]) ||
                ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: extracts and extends load data from a
// memory word, and merges store data into a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed byte/half lane and extend per funct3.
    always_comb begin
        byte_v    = word[{lane, 3'b000} +: 8];
        half_v    = word[{lane[1], 4'b0000} +: 16];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'd0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'd0, half_v};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase
    end

    // Overlay the right-justified store data onto the addressed lane.
    always_comb begin
        store_word = word;
        case (funct3[1:0])
            2'b00:   store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request
//   RD    | memory read; capture load result or merged store word
//   WR    | memory write of the full word held in data_q
//   RESP  | one-cycle completion pulse (resp_err set for rejected access)
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;   // store data, then load result / merged word
    logic                  err_q;
    logic                  accept;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    assign accept  = req_valid && (state_q == IDLE);
    assign acc_err = access_err(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3     (f3_q),
        .lane       (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (data_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register and request/data latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q   <= req_we;
                f3_q   <= req_funct3;
                addr_q <= req_addr;
                data_q <= req_wdata;
                err_q  <= acc_err;
            end else if (state_q == RD) begin
                data_q <= we_q ? store_word : load_data;
            end
        end
    end

    // Next-state decode; SW skips the read since it replaces the whole word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err)
                        state_d = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; data outputs forced to 0 when not meaningful.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? data_q : '0;
        mem_read   = (state_q == RD);
        mem_write  = (state_q == WR);
        mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata  = (state_q == WR) ? data_q : '0;
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw paired with a small word memory; expected
// responses are queued at issue and checked by a separate response monitor.
module tb_lsu_rmw;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];
    logic        mem_init;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cnt_rd  = 0;
    int cnt_wr  = 0;
    int base_rd = 0;
    int base_wr = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    lsu_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: combinational read, write on the edge after mem_write.
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[0] <= 32'h0000_0001;
            mem[1] <= 32'h1122_3344;
            mem[2] <= 32'hDEAD_BEEF;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the oldest expectation on every resp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (mem_read) cnt_rd++;
        if (mem_write) cnt_wr++;
        if (mem_read && mem_write) begin
            n_fail++;
            $display("FAIL mem_rw_excl: got read=1 write=1 expected at most one");
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none pending");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track, input logic eerr,
                         input logic [31:0] erd, input int elat, input string nm);
        exp_t e;
        int   g = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            n_fail++;
            $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
            return;
        end
        base_rd    = cnt_rd;
        base_wr    = cnt_wr;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (track) begin
            e.err   = eerr;
            e.rdata = erd;
            e.lat   = elat;
            e.acc   = cyc;
            e.name  = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs after accept; the unit must ignore them.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(input string nm);
        int g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_resp_timeout: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write},
            32'b10000);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        mem_init = 1'b0;
        rst      = 1'b0;

        // 1: LW
        issue(1'b0, F3_W, 32'h0, 32'h0, 1, 1'b0, 32'h0000_0001, 2, "t1_lw");
        wait_done("t1");

        // 2: SB into lane 1 by read-modify-write
        issue(1'b1, F3_B, 32'h5, 32'hFFFF_FFAB, 1, 1'b0, 32'h0, 3, "t2_sb");
        wait_done("t2");
        chk("t2_wr_cycles", 32'(cnt_wr - base_wr), 32'd1);
        chk("t2_mem1", mem[1], 32'h1122_AB44);

        // 3: sub-word loads from 0x1122AB44
        issue(1'b0, F3_B,  32'h6, 32'h0, 1, 1'b0, 32'h0000_0022, 2, "t3_lb6");
        issue(1'b0, F3_H,  32'h4, 32'h0, 1, 1'b0, 32'hFFFF_AB44, 2, "t3_lh4");
        issue(1'b0, F3_HU, 32'h4, 32'h0, 1, 1'b0, 32'h0000_AB44, 2, "t3_lhu4");
        issue(1'b0, F3_B,  32'h5, 32'h0, 1, 1'b0, 32'hFFFF_FFAB, 2, "t3_lb5");
        issue(1'b0, F3_BU, 32'h5, 32'h0, 1, 1'b0, 32'h0000_00AB, 2, "t3_lbu5");
        issue(1'b0, F3_H,  32'h6, 32'h0, 1, 1'b0, 32'h0000_1122, 2, "t3_lh6");
        wait_done("t3");

        // 4: misaligned accesses
        issue(1'b0, F3_W, 32'h2, 32'h0, 1, 1'b1, 32'h0, 1, "t4_lw2");
        wait_done("t4a");
        chk("t4_lw_memacc", 32'(cnt_rd - base_rd + cnt_wr - base_wr), 32'd0);
        issue(1'b1, F3_H, 32'h3, 32'h0000_BEEF, 1, 1'b1, 32'h0, 1, "t4_sh3");
        wait_done("t4b");
        chk("t4_sh_memacc", 32'(cnt_rd - base_rd + cnt_wr - base_wr), 32'd0);

        // 5: illegal funct3
        issue(1'b0, 3'b011, 32'h0, 32'h0, 1, 1'b1, 32'h0, 1, "t5_ld011");
        issue(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 1, "t5_st100");
        wait_done("t5");
        chk("t5_mem0", mem[0], 32'h0000_0001);

        // SW then SH into upper half, read back
        issue(1'b1, F3_W, 32'hC, 32'hCAFE_F00D, 1, 1'b0, 32'h0, 2, "t7_sw");
        issue(1'b1, F3_H, 32'hE, 32'h0000_5678, 1, 1'b0, 32'h0, 3, "t7_sh");
        issue(1'b0, F3_W, 32'hC, 32'h0, 1, 1'b0, 32'h5678_F00D, 2, "t7_lw");
        wait_done("t7");

        // 6: reset while in WR drops the write
        issue(1'b1, F3_H, 32'h8, 32'h0000_1234, 0, 1'b0, 32'h0, 0, "t6_sh");
        g = 0;
        while (!mem_write && g < 6) begin
            @(negedge clk);
            g++;
        end
        chk("t6_reached_wr", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write},
            32'b10000);
        chk("t6_rst_addr", mem_addr, 32'd0);
        chk("t6_rst_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_mem2", mem[2], 32'hDEAD_BEEF);
        issue(1'b0, F3_W, 32'h8, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 2, "t6_lw");
        wait_done("t6");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
